// File: rtl/axi_id_shrink_pkg.sv
// axi_id_shrink_pkg
// Shared definitions for the AXI ID width reducer:
//   - default widths for the slave-side and master-side ID fields
//   - cnt_width(): width of a per-entry outstanding-transaction counter
//   - entry_t: layout of one remap table entry (default configuration)
//   - default channel structs used when the top is not given its own types
package axi_id_shrink_pkg;

  localparam int unsigned DefaultSlvIdWidth = 6;
  localparam int unsigned DefaultMstIdWidth = 2;
  localparam int unsigned DefaultMaxTxns    = 4;
  localparam int unsigned AddrWidth         = 32;
  localparam int unsigned DataWidth         = 32;

  // A counter must be able to hold every value from 0 up to max_txns inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

  localparam int unsigned DefaultCntWidth = cnt_width(DefaultMaxTxns);

  // One remap entry. The table module declares the same layout against its
  // own parameters so that non-default widths work.
  typedef struct packed {
    logic                         valid;
    logic [DefaultSlvIdWidth-1:0] slave_id;
    logic [DefaultCntWidth-1:0]   count;
  } entry_t;

  typedef struct packed {
    logic [DefaultSlvIdWidth-1:0] id;
    logic [AddrWidth-1:0]         addr;
    logic [7:0]                   len;
  } dflt_slv_ax_t;

  typedef struct packed {
    logic [DefaultMstIdWidth-1:0] id;
    logic [AddrWidth-1:0]         addr;
    logic [7:0]                   len;
  } dflt_mst_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } dflt_w_t;

  typedef struct packed {
    logic [DefaultSlvIdWidth-1:0] id;
    logic [1:0]                   resp;
  } dflt_slv_b_t;

  typedef struct packed {
    logic [DefaultMstIdWidth-1:0] id;
    logic [1:0]                   resp;
  } dflt_mst_b_t;

  typedef struct packed {
    logic [DefaultSlvIdWidth-1:0] id;
    logic [DataWidth-1:0]         data;
    logic [1:0]                   resp;
    logic                         last;
  } dflt_slv_r_t;

  typedef struct packed {
    logic [DefaultMstIdWidth-1:0] id;
    logic [DataWidth-1:0]         data;
    logic [1:0]                   resp;
    logic                         last;
  } dflt_mst_r_t;

endpackage

// File: rtl/axi_id_shrink_table.sv
// axi_id_shrink_table
// Remap table for one direction (write or read). Maps a wide slave ID onto a
// narrow master ID (the entry index) and tracks outstanding transactions.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_valid     a request is presented
//   push_id        slave ID of that request
//   push_hs        request handshake this cycle
//   pop_idx        master ID of the response presented
//   pop_hs         response completes a transaction this cycle
//   sel_idx        entry index the request maps to
//   stall          request must not be accepted this cycle
//   pop_id         slave ID stored at pop_idx
module axi_id_shrink_table
  import axi_id_shrink_pkg::*;
#(
  parameter int unsigned SlvIdWidth = DefaultSlvIdWidth,
  parameter int unsigned MstIdWidth = DefaultMstIdWidth,
  parameter int unsigned MaxTxns    = DefaultMaxTxns
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_valid,
  input  logic [SlvIdWidth-1:0] push_id,
  input  logic                  push_hs,
  input  logic [MstIdWidth-1:0] pop_idx,
  input  logic                  pop_hs,
  output logic [MstIdWidth-1:0] sel_idx,
  output logic                  stall,
  output logic [SlvIdWidth-1:0] pop_id
);

  localparam int unsigned CntWidth   = cnt_width(MaxTxns);
  localparam int unsigned NumEntries = 1 << MstIdWidth;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxns);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  typedef struct packed {
    logic                  valid;
    logic [SlvIdWidth-1:0] slave_id;
    logic [CntWidth-1:0]   count;
  } tbl_entry_t;

  tbl_entry_t entries_q [NumEntries];

  logic                  hit;
  logic [MstIdWidth-1:0] hit_idx;
  logic                  free_found;
  logic [MstIdWidth-1:0] free_idx;
  logic [NumEntries-1:0] inc_vec;
  logic [NumEntries-1:0] dec_vec;

  // Lookup works on registered state only, so an entry freed this cycle is
  // not reusable until the next one. A saturated hit stalls rather than
  // allocating a second entry, which would break same-ID ordering.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (entries_q[i].valid && (entries_q[i].slave_id == push_id)) begin
        hit     = 1'b1;
        hit_idx = MstIdWidth'(i);
      end
      if (!entries_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = MstIdWidth'(i);
      end
    end
    sel_idx = hit ? hit_idx : free_idx;
    stall   = push_valid && (hit ? (entries_q[hit_idx].count == CntMax) : !free_found);
    pop_id  = entries_q[pop_idx].slave_id;
  end

  // Spurious responses on an empty entry are ignored to avoid underflow.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NumEntries; i++) begin
      inc_vec[i] = push_hs && (sel_idx == MstIdWidth'(i));
      dec_vec[i] = pop_hs && (pop_idx == MstIdWidth'(i)) && (entries_q[i].count != '0);
    end
  end

  // A simultaneous request and response on one entry cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumEntries; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          entries_q[i].valid    <= 1'b1;
          entries_q[i].slave_id <= push_id;
          entries_q[i].count    <= entries_q[i].count + CntOne;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          entries_q[i].count <= entries_q[i].count - CntOne;
          if (entries_q[i].count == CntOne) begin
            entries_q[i].valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/axi_id_shrink.sv
// axi_id_shrink
// Narrows AXI IDs from AxiIdWidthSlvPort to AxiIdWidthMstPort bits by
// remapping each in-flight slave ID onto a free master ID, and restores the
// original ID on B and R. Zero-latency; all outputs are combinational from
// inputs and table state.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   slv_aw_* / mst_aw_*                AW in (wide ID) / out (remapped ID)
//   slv_w_*  / mst_w_*                 W pass-through
//   mst_b_*  / slv_b_*                 B in (narrow ID) / out (restored ID)
//   slv_ar_* / mst_ar_*                AR in / out
//   mst_r_*  / slv_r_*                 R in / out
module axi_id_shrink
  import axi_id_shrink_pkg::*;
#(
  parameter int unsigned AxiIdWidthSlvPort = DefaultSlvIdWidth,
  parameter int unsigned AxiIdWidthMstPort = DefaultMstIdWidth,
  parameter int unsigned MaxTxnsPerId      = DefaultMaxTxns,
  parameter type slv_aw_chan_t = dflt_slv_ax_t,
  parameter type slv_w_chan_t  = dflt_w_t,
  parameter type slv_b_chan_t  = dflt_slv_b_t,
  parameter type slv_ar_chan_t = dflt_slv_ax_t,
  parameter type slv_r_chan_t  = dflt_slv_r_t,
  parameter type mst_aw_chan_t = dflt_mst_ax_t,
  parameter type mst_w_chan_t  = dflt_w_t,
  parameter type mst_b_chan_t  = dflt_mst_b_t,
  parameter type mst_ar_chan_t = dflt_mst_ax_t,
  parameter type mst_r_chan_t  = dflt_mst_r_t
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  slv_aw_chan_t slv_aw_chan_i,
  input  logic         slv_aw_valid_i,
  output logic         slv_aw_ready_o,
  output mst_aw_chan_t mst_aw_chan_o,
  output logic         mst_aw_valid_o,
  input  logic         mst_aw_ready_i,
  input  slv_w_chan_t  slv_w_chan_i,
  input  logic         slv_w_valid_i,
  output logic         slv_w_ready_o,
  output mst_w_chan_t  mst_w_chan_o,
  output logic         mst_w_valid_o,
  input  logic         mst_w_ready_i,
  input  mst_b_chan_t  mst_b_chan_i,
  input  logic         mst_b_valid_i,
  output logic         mst_b_ready_o,
  output slv_b_chan_t  slv_b_chan_o,
  output logic         slv_b_valid_o,
  input  logic         slv_b_ready_i,
  input  slv_ar_chan_t slv_ar_chan_i,
  input  logic         slv_ar_valid_i,
  output logic         slv_ar_ready_o,
  output mst_ar_chan_t mst_ar_chan_o,
  output logic         mst_ar_valid_o,
  input  logic         mst_ar_ready_i,
  input  mst_r_chan_t  mst_r_chan_i,
  input  logic         mst_r_valid_i,
  output logic         mst_r_ready_o,
  output slv_r_chan_t  slv_r_chan_o,
  output logic         slv_r_valid_o,
  input  logic         slv_r_ready_i
);

  if (AxiIdWidthSlvPort <= AxiIdWidthMstPort) begin : g_bad_id_width
    $error("axi_id_shrink: AxiIdWidthSlvPort must exceed AxiIdWidthMstPort");
  end
  if (MaxTxnsPerId < 1) begin : g_bad_max_txns
    $error("axi_id_shrink: MaxTxnsPerId must be at least 1");
  end

  logic [AxiIdWidthMstPort-1:0] wr_idx;
  logic [AxiIdWidthMstPort-1:0] rd_idx;
  logic                         wr_stall;
  logic                         rd_stall;
  logic [AxiIdWidthSlvPort-1:0] wr_pop_id;
  logic [AxiIdWidthSlvPort-1:0] rd_pop_id;
  logic                         wr_push_hs;
  logic                         rd_push_hs;
  logic                         wr_pop_hs;
  logic                         rd_pop_hs;

  axi_id_shrink_table #(
    .SlvIdWidth (AxiIdWidthSlvPort),
    .MstIdWidth (AxiIdWidthMstPort),
    .MaxTxns    (MaxTxnsPerId)
  ) i_wr_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_valid (slv_aw_valid_i),
    .push_id    (slv_aw_chan_i.id),
    .push_hs    (wr_push_hs),
    .pop_idx    (mst_b_chan_i.id),
    .pop_hs     (wr_pop_hs),
    .sel_idx    (wr_idx),
    .stall      (wr_stall),
    .pop_id     (wr_pop_id)
  );

  axi_id_shrink_table #(
    .SlvIdWidth (AxiIdWidthSlvPort),
    .MstIdWidth (AxiIdWidthMstPort),
    .MaxTxns    (MaxTxnsPerId)
  ) i_rd_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_valid (slv_ar_valid_i),
    .push_id    (slv_ar_chan_i.id),
    .push_hs    (rd_push_hs),
    .pop_idx    (mst_r_chan_i.id),
    .pop_hs     (rd_pop_hs),
    .sel_idx    (rd_idx),
    .stall      (rd_stall),
    .pop_id     (rd_pop_id)
  );

  // Request valid never looks at downstream ready, keeping AXI's
  // valid-before-ready rule intact. Requests are blocked while in reset.
  always_comb begin
    mst_aw_valid_o = slv_aw_valid_i && !wr_stall && !rst_i;
    slv_aw_ready_o = mst_aw_ready_i && !wr_stall && !rst_i;
    mst_ar_valid_o = slv_ar_valid_i && !rd_stall && !rst_i;
    slv_ar_ready_o = mst_ar_ready_i && !rd_stall && !rst_i;
    wr_push_hs     = slv_aw_valid_i && slv_aw_ready_o;
    rd_push_hs     = slv_ar_valid_i && slv_ar_ready_o;
  end

  always_comb begin
    mst_aw_chan_o      = '0;
    mst_aw_chan_o.id   = wr_idx;
    mst_aw_chan_o.addr = slv_aw_chan_i.addr;
    mst_aw_chan_o.len  = slv_aw_chan_i.len;
    mst_ar_chan_o      = '0;
    mst_ar_chan_o.id   = rd_idx;
    mst_ar_chan_o.addr = slv_ar_chan_i.addr;
    mst_ar_chan_o.len  = slv_ar_chan_i.len;
  end

  assign mst_w_chan_o  = slv_w_chan_i;
  assign mst_w_valid_o = slv_w_valid_i;
  assign slv_w_ready_o = mst_w_ready_i;

  // A read transaction is only complete on its last beat.
  always_comb begin
    slv_b_chan_o      = '0;
    slv_b_chan_o.id   = wr_pop_id;
    slv_b_chan_o.resp = mst_b_chan_i.resp;
    slv_b_valid_o     = mst_b_valid_i;
    mst_b_ready_o     = slv_b_ready_i;
    wr_pop_hs         = mst_b_valid_i && slv_b_ready_i;
    slv_r_chan_o      = '0;
    slv_r_chan_o.id   = rd_pop_id;
    slv_r_chan_o.data = mst_r_chan_i.data;
    slv_r_chan_o.resp = mst_r_chan_i.resp;
    slv_r_chan_o.last = mst_r_chan_i.last;
    slv_r_valid_o     = mst_r_valid_i;
    mst_r_ready_o     = slv_r_ready_i;
    rd_pop_hs         = mst_r_valid_i && slv_r_ready_i && mst_r_chan_i.last;
  end

endmodule

// File: tb/tb_axi_id_shrink.sv
// tb_axi_id_shrink
// Randomised and directed stimulus against a map-based reference model.
// Expected requests/responses go into queues; a negedge monitor pops and
// compares whenever the DUT completes a handshake.
module tb_axi_id_shrink;
  import axi_id_shrink_pkg::*;

  localparam int NUM  = 4;
  localparam int MAXT = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  dflt_slv_ax_t slv_aw_chan_i;
  logic         slv_aw_valid_i, slv_aw_ready_o;
  dflt_mst_ax_t mst_aw_chan_o;
  logic         mst_aw_valid_o, mst_aw_ready_i;
  dflt_w_t      slv_w_chan_i, mst_w_chan_o;
  logic         slv_w_valid_i, slv_w_ready_o, mst_w_valid_o, mst_w_ready_i;
  dflt_mst_b_t  mst_b_chan_i;
  logic         mst_b_valid_i, mst_b_ready_o;
  dflt_slv_b_t  slv_b_chan_o;
  logic         slv_b_valid_o, slv_b_ready_i;
  dflt_slv_ax_t slv_ar_chan_i;
  logic         slv_ar_valid_i, slv_ar_ready_o;
  dflt_mst_ax_t mst_ar_chan_o;
  logic         mst_ar_valid_o, mst_ar_ready_i;
  dflt_mst_r_t  mst_r_chan_i;
  logic         mst_r_valid_i, mst_r_ready_o;
  dflt_slv_r_t  slv_r_chan_o;
  logic         slv_r_valid_o, slv_r_ready_i;

  always #5 clk_i = ~clk_i;

  axi_id_shrink dut (
    .clk_i, .rst_i,
    .slv_aw_chan_i, .slv_aw_valid_i, .slv_aw_ready_o,
    .mst_aw_chan_o, .mst_aw_valid_o, .mst_aw_ready_i,
    .slv_w_chan_i, .slv_w_valid_i, .slv_w_ready_o,
    .mst_w_chan_o, .mst_w_valid_o, .mst_w_ready_i,
    .mst_b_chan_i, .mst_b_valid_i, .mst_b_ready_o,
    .slv_b_chan_o, .slv_b_valid_o, .slv_b_ready_i,
    .slv_ar_chan_i, .slv_ar_valid_i, .slv_ar_ready_o,
    .mst_ar_chan_o, .mst_ar_valid_o, .mst_ar_ready_i,
    .mst_r_chan_i, .mst_r_valid_i, .mst_r_ready_o,
    .slv_r_chan_o, .slv_r_valid_o, .slv_r_ready_i
  );

  int checks = 0;
  int fails  = 0;

  dflt_mst_ax_t aw_q[$];
  dflt_mst_ax_t ar_q[$];
  dflt_slv_b_t  b_q[$];
  dflt_slv_r_t  r_q[$];

  // Reference model: index 0 = write table, 1 = read table.
  // owner = slave ID mapped to a master ID, cnt = outstanding transactions.
  int owner[2][NUM];
  int cnt[2][NUM];

  typedef struct {
    bit aw; int aw_id; bit b; int b_idx;
    bit ar; int ar_id; bit r; int r_idx; bit r_last;
    bit mrdy; bit srdy;
  } cyc_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int t = 0; t < 2; t++)
      for (int k = 0; k < NUM; k++) begin
        owner[t][k] = 0;
        cnt[t][k]   = 0;
      end
  endfunction

  // Same ID reuses its master ID (stalling when full); a new ID takes the
  // lowest master ID with nothing outstanding.
  function automatic void model_lookup(input int t, input int x, output bit stall, output int idx);
    idx = -1;
    for (int k = 0; k < NUM; k++)
      if (cnt[t][k] > 0 && owner[t][k] == x) idx = k;
    if (idx >= 0) begin
      stall = (cnt[t][idx] >= MAXT);
      return;
    end
    stall = 1'b1;
    idx   = 0;
    for (int k = NUM - 1; k >= 0; k--)
      if (cnt[t][k] == 0) begin
        idx   = k;
        stall = 1'b0;
      end
  endfunction

  function automatic cyc_t idle();
    cyc_t c;
    c = '{default: 0};
    c.mrdy = 1'b1;
    c.srdy = 1'b1;
    return c;
  endfunction

  // Called just after a rising edge; leaves just after the next one.
  task automatic applyStimulus(input cyc_t c);
    bit aw_stall, ar_stall, aw_hs, ar_hs, b_hs, r_hs;
    int aw_idx, ar_idx;
    dflt_mst_ax_t exp_ax;
    dflt_slv_b_t  exp_b;
    dflt_slv_r_t  exp_r;
    logic [38:0]  exp_w;
    model_lookup(0, c.aw_id, aw_stall, aw_idx);
    model_lookup(1, c.ar_id, ar_stall, ar_idx);
    aw_hs = c.aw && c.mrdy && !aw_stall;
    ar_hs = c.ar && c.mrdy && !ar_stall;
    b_hs  = c.b && c.srdy;
    r_hs  = c.r && c.srdy;

    slv_aw_valid_i     = c.aw;
    slv_aw_chan_i.id   = 6'(c.aw_id);
    slv_aw_chan_i.addr = $urandom;
    slv_aw_chan_i.len  = 8'($urandom);
    mst_aw_ready_i     = c.mrdy;
    slv_ar_valid_i     = c.ar;
    slv_ar_chan_i.id   = 6'(c.ar_id);
    slv_ar_chan_i.addr = $urandom;
    slv_ar_chan_i.len  = 8'($urandom);
    mst_ar_ready_i     = c.mrdy;
    mst_b_valid_i      = c.b;
    mst_b_chan_i.id    = 2'(c.b_idx);
    mst_b_chan_i.resp  = 2'($urandom);
    slv_b_ready_i      = c.srdy;
    mst_r_valid_i      = c.r;
    mst_r_chan_i.id    = 2'(c.r_idx);
    mst_r_chan_i.data  = $urandom;
    mst_r_chan_i.resp  = 2'($urandom);
    mst_r_chan_i.last  = c.r_last;
    slv_r_ready_i      = c.srdy;
    slv_w_valid_i      = 1'($urandom);
    mst_w_ready_i      = 1'($urandom);
    slv_w_chan_i       = dflt_w_t'({$urandom, $urandom});
    exp_w              = {slv_w_valid_i, mst_w_ready_i, slv_w_chan_i};

    if (aw_hs) begin
      exp_ax.id = 2'(aw_idx); exp_ax.addr = slv_aw_chan_i.addr; exp_ax.len = slv_aw_chan_i.len;
      aw_q.push_back(exp_ax);
    end
    if (ar_hs) begin
      exp_ax.id = 2'(ar_idx); exp_ax.addr = slv_ar_chan_i.addr; exp_ax.len = slv_ar_chan_i.len;
      ar_q.push_back(exp_ax);
    end
    if (b_hs) begin
      exp_b.id = 6'(owner[0][c.b_idx]); exp_b.resp = mst_b_chan_i.resp;
      b_q.push_back(exp_b);
    end
    if (r_hs) begin
      exp_r.id = 6'(owner[1][c.r_idx]); exp_r.data = mst_r_chan_i.data;
      exp_r.resp = mst_r_chan_i.resp; exp_r.last = c.r_last;
      r_q.push_back(exp_r);
    end

    @(negedge clk_i);
    if (c.aw) begin
      checkOutput("aw_ready", 64'(slv_aw_ready_o), 64'(aw_hs));
      checkOutput("aw_valid", 64'(mst_aw_valid_o), 64'(!aw_stall));
    end
    if (c.ar) begin
      checkOutput("ar_ready", 64'(slv_ar_ready_o), 64'(ar_hs));
      checkOutput("ar_valid", 64'(mst_ar_valid_o), 64'(!ar_stall));
    end
    if (c.b) checkOutput("b_valid", 64'({slv_b_valid_o, mst_b_ready_o}), 64'({1'b1, c.srdy}));
    if (c.r) checkOutput("r_valid", 64'({slv_r_valid_o, mst_r_ready_o}), 64'({1'b1, c.srdy}));
    checkOutput("w_pass", 64'({mst_w_valid_o, slv_w_ready_o, mst_w_chan_o}), 64'(exp_w));

    @(posedge clk_i);
    #1;
    if (aw_hs) begin owner[0][aw_idx] = c.aw_id; cnt[0][aw_idx]++; end
    if (b_hs && cnt[0][c.b_idx] > 0) cnt[0][c.b_idx]--;
    if (ar_hs) begin owner[1][ar_idx] = c.ar_id; cnt[1][ar_idx]++; end
    if (r_hs && c.r_last && cnt[1][c.r_idx] > 0) cnt[1][c.r_idx]--;
  endtask

  task automatic do_aw(input int id);
    cyc_t c = idle(); c.aw = 1; c.aw_id = id; applyStimulus(c);
  endtask
  task automatic do_ar(input int id);
    cyc_t c = idle(); c.ar = 1; c.ar_id = id; applyStimulus(c);
  endtask
  task automatic do_b(input int idx);
    cyc_t c = idle(); c.b = 1; c.b_idx = idx; applyStimulus(c);
  endtask
  task automatic do_r(input int idx, input bit last);
    cyc_t c = idle(); c.r = 1; c.r_idx = idx; c.r_last = last; applyStimulus(c);
  endtask

  dflt_mst_ax_t mon_ax;
  dflt_slv_b_t  mon_b;
  dflt_slv_r_t  mon_r;

  always @(negedge clk_i) begin
    if (mst_aw_valid_o && mst_aw_ready_i) begin
      if (aw_q.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL aw_unexpected: got id 0x%0h, expected no request", mst_aw_chan_o.id);
      end else begin
        mon_ax = aw_q.pop_front();
        checkOutput("aw_chan", 64'(mst_aw_chan_o), 64'(mon_ax));
      end
    end
    if (mst_ar_valid_o && mst_ar_ready_i) begin
      if (ar_q.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL ar_unexpected: got id 0x%0h, expected no request", mst_ar_chan_o.id);
      end else begin
        mon_ax = ar_q.pop_front();
        checkOutput("ar_chan", 64'(mst_ar_chan_o), 64'(mon_ax));
      end
    end
    if (slv_b_valid_o && slv_b_ready_i) begin
      if (b_q.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL b_unexpected: got id 0x%0h, expected no response", slv_b_chan_o.id);
      end else begin
        mon_b = b_q.pop_front();
        checkOutput("b_chan", 64'(slv_b_chan_o), 64'(mon_b));
      end
    end
    if (slv_r_valid_o && slv_r_ready_i) begin
      if (r_q.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL r_unexpected: got id 0x%0h, expected no response", slv_r_chan_o.id);
      end else begin
        mon_r = r_q.pop_front();
        checkOutput("r_chan", 64'(slv_r_chan_o), 64'(mon_r));
      end
    end
  end

  task automatic check_reset_blocks();
    @(negedge clk_i);
    checkOutput("rst_aw_ready", 64'(slv_aw_ready_o), 64'(0));
    checkOutput("rst_aw_valid", 64'(mst_aw_valid_o), 64'(0));
    checkOutput("rst_ar_ready", 64'(slv_ar_ready_o), 64'(0));
    checkOutput("rst_ar_valid", 64'(mst_ar_valid_o), 64'(0));
  endtask

  initial begin
    cyc_t c;
    int outstanding[$];
    rst_i = 1'b1;
    slv_aw_chan_i = '0; slv_ar_chan_i = '0; slv_w_chan_i = '0;
    mst_b_chan_i = '0; mst_r_chan_i = '0;
    slv_w_valid_i = 0; mst_w_ready_i = 0; mst_b_valid_i = 0; mst_r_valid_i = 0;
    slv_b_ready_i = 1; slv_r_ready_i = 1;
    slv_aw_valid_i = 1; mst_aw_ready_i = 1; slv_ar_valid_i = 1; mst_ar_ready_i = 1;
    model_reset();
    repeat (2) @(posedge clk_i);
    check_reset_blocks();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; slv_aw_valid_i = 0; slv_ar_valid_i = 0;

    // first request after reset, response restore, freed entry reuse
    do_aw('h2A);
    do_b(0);
    do_aw('h11);
    do_b(0);

    // saturation on one ID, released by a single B
    repeat (5) do_aw('h05);
    do_aw('h05);
    c = idle(); c.aw = 1; c.aw_id = 'h05; c.b = 1; c.b_idx = 0; applyStimulus(c);
    do_aw('h05);
    repeat (4) do_b(0);

    // full read table, freed entry taken by the waiting ID
    for (int i = 1; i <= 4; i++) do_ar(i);
    repeat (2) do_ar('h05);
    c = idle(); c.ar = 1; c.ar_id = 'h05; c.r = 1; c.r_idx = 2; c.r_last = 1; applyStimulus(c);
    do_ar('h05);
    do_r(0, 1); do_r(1, 1); do_r(3, 1); do_r(2, 1);

    // burst: only the last beat releases the entry
    do_ar('h10); do_ar('h20);
    do_r(1, 0); do_r(1, 0);
    do_ar('h30);
    do_r(1, 1);
    do_ar('h40);
    do_r(0, 1); do_r(2, 1); do_r(1, 1);

    // request and response on the same entry in one cycle
    do_aw('h05);
    c = idle(); c.aw = 1; c.aw_id = 'h05; c.b = 1; c.b_idx = 0; applyStimulus(c);
    do_b(0);
    do_aw('h33);
    do_b(0);

    // reset with transactions outstanding
    do_aw('h07); do_aw('h08); do_ar('h09);
    rst_i = 1'b1;
    mst_b_valid_i = 0; mst_r_valid_i = 0;
    slv_aw_valid_i = 1; slv_ar_valid_i = 1;
    check_reset_blocks();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; slv_aw_valid_i = 0; slv_ar_valid_i = 0;
    model_reset();
    do_aw('h3F); do_ar('h3E);
    do_b(0); do_r(0, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      c = idle();
      c.mrdy  = ($urandom_range(0, 3) != 0);
      c.srdy  = ($urandom_range(0, 3) != 0);
      c.aw    = 1'($urandom_range(0, 1));
      c.aw_id = $urandom_range(0, 7);
      c.ar    = 1'($urandom_range(0, 1));
      c.ar_id = $urandom_range(0, 7);
      outstanding.delete();
      for (int k = 0; k < NUM; k++) if (cnt[0][k] > 0) outstanding.push_back(k);
      if (outstanding.size() > 0 && $urandom_range(0, 2) != 0) begin
        c.b = 1; c.b_idx = outstanding[$urandom_range(0, outstanding.size() - 1)];
      end
      outstanding.delete();
      for (int k = 0; k < NUM; k++) if (cnt[1][k] > 0) outstanding.push_back(k);
      if (outstanding.size() > 0 && $urandom_range(0, 2) != 0) begin
        c.r = 1; c.r_idx = outstanding[$urandom_range(0, outstanding.size() - 1)];
        c.r_last = ($urandom_range(0, 2) == 0);
      end
      applyStimulus(c);
    end

    // drain everything still outstanding
    for (int n = 0; n < 100; n++) begin
      c = idle();
      for (int k = 0; k < NUM; k++) begin
        if (cnt[0][k] > 0) begin c.b = 1; c.b_idx = k; end
        if (cnt[1][k] > 0) begin c.r = 1; c.r_idx = k; c.r_last = 1; end
      end
      applyStimulus(c);
    end
    do_aw('h01);
    do_b(0);
    applyStimulus(idle());

    checkOutput("aw_q_empty", 64'(aw_q.size()), 64'(0));
    checkOutput("ar_q_empty", 64'(ar_q.size()), 64'(0));
    checkOutput("b_q_empty", 64'(b_q.size()), 64'(0));
    checkOutput("r_q_empty", 64'(r_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
